// File: rtl/pipelined_tree_adder.sv
// Pipelined N-operand binary tree adder with valid/ready backpressure, one register stage per level.
// Define TREE_SIGNED_EN to treat operands (and sum) as two's complement; default build is unsigned.
module pipelined_tree_adder #(
  parameter int W = 16,
  parameter int N = 4,
  localparam int LOG2N = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*W-1:0]       in_ops,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W+LOG2N-1:0]   sum
);

`ifdef TREE_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("pipelined_tree_adder: N must be a power of 2 and at least 2");
  end

  // Whole tree moves in lockstep: any stall at the output freezes every level.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 1; k <= LOG2N; k++) begin : lvl
    localparam int CNT = N >> k;
    localparam int PW  = W + k;

    logic [PW-1:0] psum [CNT];
    logic [PW-1:0] nxt  [CNT];
    logic          vld;
    logic          src_vld;

    if (k == 1) begin : g_leaf
      assign src_vld = in_valid;

      // Carry-in only enters through the first leaf pair.
      always_comb begin
        for (int j = 0; j < CNT; j++) begin
          nxt[j] = {SGN & in_ops[(2*j+1)*W-1], in_ops[2*j*W +: W]}
                 + {SGN & in_ops[(2*j+2)*W-1], in_ops[(2*j+1)*W +: W]}
                 + PW'((j == 0) ? cin : 1'b0);
        end
      end
    end else begin : g_node
      assign src_vld = lvl[k-1].vld;

      always_comb begin
        for (int j = 0; j < CNT; j++) begin
          nxt[j] = {SGN & lvl[k-1].psum[2*j][PW-2],   lvl[k-1].psum[2*j]}
                 + {SGN & lvl[k-1].psum[2*j+1][PW-2], lvl[k-1].psum[2*j+1]};
        end
      end
    end

    // Data only loads behind a valid set, so bubbles leave the previous sum in place.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld <= 1'b0;
        for (int j = 0; j < CNT; j++) psum[j] <= '0;
      end else if (adv) begin
        vld <= src_vld;
        if (src_vld) begin
          for (int j = 0; j < CNT; j++) psum[j] <= nxt[j];
        end
      end
    end
  end

  assign out_valid = lvl[LOG2N].vld;
  assign sum       = lvl[LOG2N].psum[0];

endmodule

// File: tb/tb_pipelined_tree_adder.sv
// Directed + randomized bench for pipelined_tree_adder (W=16, N=4) with a queue scoreboard.
module tb_pipelined_tree_adder;

  localparam int W     = 16;
  localparam int N     = 4;
  localparam int LOG2N = 2;
  localparam int SW    = W + LOG2N;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [N*W-1:0]  in_ops;
  logic            cin;
  logic            out_valid;
  logic            out_ready;
  logic [SW-1:0]   sum;

  int passed = 0;
  int total  = 0;
  int popped = 0;

  logic [SW-1:0] sbq [$];
  logic          stall_prev = 1'b0;
  logic [SW-1:0] sum_prev   = '0;

  pipelined_tree_adder #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ops    (in_ops),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum)
  );

  always #5 clk = ~clk;

  function automatic logic [SW-1:0] model(input logic [N*W-1:0] ops, input logic c);
    longint acc = 0;
    for (int i = 0; i < N; i++) begin
`ifdef TREE_SIGNED_EN
      acc += longint'($signed(ops[i*W +: W]));
`else
      acc += longint'(ops[i*W +: W]);
`endif
    end
    acc += longint'(c);
    return acc[SW-1:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic v, input logic [W-1:0] o0, input logic [W-1:0] o1,
                               input logic [W-1:0] o2, input logic [W-1:0] o3, input logic c);
    in_valid = v;
    in_ops   = {o3, o2, o1, o0};
    cin      = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on input handshake, pop and compare on output handshake, mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checkOutput("hold_valid", 64'(out_valid), 64'd1);
        checkOutput("hold_sum", 64'(sum), 64'(sum_prev));
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checkOutput("spurious_out", 64'(out_valid), 64'd0);
        end else begin
          checkOutput("sb_sum", 64'(sum), 64'(sbq.pop_front()));
          popped++;
        end
      end
      if (in_valid && in_ready) sbq.push_back(model(in_ops, cin));
      stall_prev = out_valid && !out_ready;
      sum_prev   = sum;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int            p0;
    int            guard;
    logic [W-1:0]  r0, r1, r2, r3;

    rst = 1'b1; out_ready = 1'b1;
    applyStimulus(1'b0, '0, '0, '0, '0, 1'b0);
    repeat (2) tick();
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_sum", 64'(sum), 64'd0);
    rst = 1'b0;
    tick();
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);

    // Basic sum and exact two-cycle latency
    applyStimulus(1'b1, 16'hEEAD, 16'h2A6E, 16'hD5DB, 16'hFFFF, 1'b0);
    tick();
    applyStimulus(1'b0, '0, '0, '0, '0, 1'b0);
    checkOutput("lat_early", 64'(out_valid), 64'd0);
    tick();
    checkOutput("lat_valid", 64'(out_valid), 64'd1);
    checkOutput("basic_sum", 64'(sum), 64'h2EEF5);
    tick();
    checkOutput("lat_one_cycle", 64'(out_valid), 64'd0);

    // Saturation and all-zero
    applyStimulus(1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1);
    tick();
    applyStimulus(1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    tick();
    applyStimulus(1'b0, '0, '0, '0, '0, 1'b0);
    checkOutput("sat_valid", 64'(out_valid), 64'd1);
    checkOutput("sat_sum", 64'(sum), 64'h3FFFD);
    tick();
    checkOutput("zero_valid", 64'(out_valid), 64'd1);
    checkOutput("zero_sum", 64'(sum), 64'h0);
    repeat (2) tick();

    // Back-to-back streaming
    p0 = popped;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, W'(k), W'(k), W'(k), W'(k), 1'b0);
      checkOutput("stream_in_ready", 64'(in_ready), 64'd1);
      if (k >= 2) checkOutput("stream_sum", 64'(sum), 64'(4 * (k - 2)));
      tick();
    end
    applyStimulus(1'b0, '0, '0, '0, '0, 1'b0);
    repeat (3) tick();
    checkOutput("stream_count", 64'(popped - p0), 64'd8);

    // Backpressure: third set refused until the consumer takes the first
    out_ready = 1'b0;
    p0 = popped;
    applyStimulus(1'b1, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 1'b0);
    checkOutput("bp_ready_a", 64'(in_ready), 64'd1);
    tick();
    applyStimulus(1'b1, 16'h0010, 16'h0020, 16'h0030, 16'h0040, 1'b1);
    checkOutput("bp_ready_b", 64'(in_ready), 64'd1);
    tick();
    applyStimulus(1'b1, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 1'b0);
    checkOutput("bp_ready_c", 64'(in_ready), 64'd0);
    checkOutput("bp_valid", 64'(out_valid), 64'd1);
    checkOutput("bp_sum", 64'(sum), 64'h0000A);
    tick();
    checkOutput("bp_hold_sum", 64'(sum), 64'h0000A);
    checkOutput("bp_ready_c2", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1;
    checkOutput("bp_ready_resume", 64'(in_ready), 64'd1);
    tick();
    applyStimulus(1'b0, '0, '0, '0, '0, 1'b0);
    checkOutput("bp_sum_b", 64'(sum), 64'h000A1);
    tick();
    checkOutput("bp_sum_c", 64'(sum), 64'h00A00);
    tick();
    checkOutput("bp_count", 64'(popped - p0), 64'd3);

    // Reset with two sets in flight
    out_ready = 1'b0;
    applyStimulus(1'b1, 16'h1111, 16'h1111, 16'h1111, 16'h1111, 1'b0);
    tick();
    applyStimulus(1'b1, 16'h2222, 16'h2222, 16'h2222, 16'h2222, 1'b0);
    tick();
    applyStimulus(1'b0, '0, '0, '0, '0, 1'b0);
    checkOutput("mid_pre_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid_rst_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_rst_sum", 64'(sum), 64'd0);
    out_ready = 1'b1;
    p0 = popped;
    repeat (3) tick();
    checkOutput("mid_no_ghost", 64'(out_valid), 64'd0);
    checkOutput("mid_no_pop", 64'(popped - p0), 64'd0);
    r0 = W'($urandom); r1 = W'($urandom); r2 = W'($urandom); r3 = W'($urandom);
    applyStimulus(1'b1, r0, r1, r2, r3, 1'b1);
    tick();
    applyStimulus(1'b0, '0, '0, '0, '0, 1'b0);
    checkOutput("post_rst_early", 64'(out_valid), 64'd0);
    tick();
    checkOutput("post_rst_valid", 64'(out_valid), 64'd1);
    checkOutput("post_rst_sum", 64'(sum), 64'(model({r3, r2, r1, r0}, 1'b1)));
    tick();

    // Sign handling of the most negative operands
    applyStimulus(1'b1, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 1'b0);
    tick();
    applyStimulus(1'b0, '0, '0, '0, '0, 1'b0);
    tick();
`ifdef TREE_SIGNED_EN
    checkOutput("sign_sum", 64'(sum), 64'h30000);
`else
    checkOutput("sign_sum", 64'(sum), 64'h10000);
`endif
    tick();

    // Random traffic with random backpressure
    for (int i = 0; i < 60; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      applyStimulus(1'($urandom_range(0, 1)), W'($urandom), W'($urandom),
                    W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      tick();
    end
    out_ready = 1'b1;
    applyStimulus(1'b0, '0, '0, '0, '0, 1'b0);
    guard = 0;
    while (sbq.size() != 0 && guard < 20) begin
      tick();
      guard++;
    end
    checkOutput("drain_empty", 64'(sbq.size()), 64'd0);
    tick();
    checkOutput("drain_idle", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
